// File: rtl/cpu_pkg.sv
// Shared CPU constants: branch opcode, condition codes, flag bit positions
// and the branch sequencing FSM state type.
package cpu_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b00111;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  // Flag vector layout is {N,V,Z}
  localparam int NVZ_N = 2;
  localparam int NVZ_V = 1;
  localparam int NVZ_Z = 0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_REDIRECT,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: (cond, {N,V,Z}) -> taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic [2:0] i_nvz,
  output logic       o_taken
);

  logic w_n, w_v, w_z;

  assign w_n = i_nvz[NVZ_N];
  assign w_v = i_nvz[NVZ_V];
  assign w_z = i_nvz[NVZ_Z];

  // NOTE: assign a default before the case so no path leaves o_taken unassigned (no latch).
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_NE: o_taken = ~w_z;
      COND_EQ: o_taken = w_z;
      COND_GT: o_taken = ~w_z & ~w_n;
      COND_LT: o_taken = w_n;
      COND_GE: o_taken = ~w_n;
      COND_LE: o_taken = w_n | w_z;
      COND_OV: o_taken = w_v;
      COND_UN: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_ctrl.sv
// Branch sequencing controller: owns {N,V,Z}, scoreboards in-flight flag
// writers, stalls decode on stale flags and drives redirect/flush.
module branch_flag_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_PEND     = 3,
  parameter int PC_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_opcode,
  input  logic [2:0]      id_cond,
  input  logic            id_sets_flags,
  input  logic [PC_W-1:0] id_target,
  input  logic            wb_flag_we,
  input  logic [2:0]      wb_nvz,
  output logic            stall_id,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [2:0]      flags_q,
  output logic            pend_err
);

  localparam int PEND_W   = $clog2(MAX_PEND + 1);
  localparam int CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam int CNT_INIT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

  state_t            r_state;
  logic [PEND_W-1:0] r_pend;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [2:0]        r_flags;
  logic              r_redirect_valid;
  logic [PC_W-1:0]   r_redirect_pc;
  logic              r_flush;
  logic              r_pend_err;

  logic              w_is_branch;
  logic              w_taken;
  logic              w_pend_full;
  logic              w_issue;
  logic              w_inc;
  logic              w_dec;
  logic [PEND_W-1:0] w_pend_next;

  branch_cond u_branch_cond (
    .i_cond  (id_cond),
    .i_nvz   (r_flags),
    .o_taken (w_taken)
  );

  assign w_is_branch = id_valid & (id_opcode == OP_BRANCH);
  assign w_pend_full = id_valid & id_sets_flags & (r_pend == PEND_W'(MAX_PEND)) & ~wb_flag_we;

  always_comb begin
    stall_id = 1'b1;
    if (r_state == ST_RUN) stall_id = (w_is_branch & (r_pend != '0)) | w_pend_full;
  end

  assign w_issue = id_valid & ~stall_id & (r_state == ST_RUN);
  assign w_inc   = w_issue & id_sets_flags;
  // A writeback with nothing pending is an error, not a decrement
  assign w_dec   = wb_flag_we & (r_pend != '0);

  always_comb begin
    w_pend_next = r_pend;
    if (w_inc & ~w_dec) w_pend_next = r_pend + PEND_W'(1);
    if (~w_inc & w_dec) w_pend_next = r_pend - PEND_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_RUN;
      r_pend           <= '0;
      r_flush_cnt      <= '0;
      r_flags          <= 3'b000;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_pend_err       <= 1'b0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_pend           <= w_pend_next;
      if (wb_flag_we) r_flags <= wb_nvz;
      if (wb_flag_we && r_pend == '0) r_pend_err <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (w_is_branch) begin
            if (r_pend != '0) begin
              r_state <= ST_WAIT;
            end else if (w_taken) begin
              r_state          <= ST_REDIRECT;
              r_redirect_pc    <= id_target;
              r_redirect_valid <= 1'b1;
              r_flush          <= 1'b1;
              r_flush_cnt      <= CNT_W'(CNT_INIT);
            end
          end
        end
        // Leave as soon as the count settles to zero so RUN sees pend==0 and fresh flags
        ST_WAIT: if (w_pend_next == '0) r_state <= ST_RUN;
        ST_REDIRECT: begin
          if (FLUSH_CYCLES > 1) begin
            r_state <= ST_FLUSH;
          end else begin
            r_state <= ST_RUN;
            r_flush <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ST_RUN;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign flags_q        = r_flags;
  assign pend_err       = r_pend_err;

endmodule
